// File: rtl/sine_quadrant_sequencer.sv
// Quarter-wave sine sequencer: walks a quarter-wave sample memory forward and backward
// over four quadrants and rebuilds a full-period offset-binary sample stream.
module sine_quadrant_sequencer #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 9,
    parameter int STEP_DIV   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    output logic [ADDR_WIDTH-1:0] read_address,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH:0]   sample_out,
    output logic                  sample_valid,
    output logic [1:0]            quadrant,
    output logic                  period_start
);

    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0]         CNT_LAST  = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0]         CNT_ZERO  = PW'(32'd0);
    localparam logic [PW-1:0]         CNT_ONE   = PW'(32'd1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(32'd1);
    localparam logic [DATA_WIDTH:0]   MIDSCALE  = {1'b1, {DATA_WIDTH{1'b0}}};

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    quad_t                 quad_r;
    quad_t                 quad_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [ADDR_WIDTH-1:0] addr_nxt_s;
    logic [PW-1:0]         cnt_r;
    logic                  step_s;
    logic                  tag_neg_s;
    logic                  tag_first_s;
    logic                  valid1_r;
    logic                  neg1_r;
    logic                  first1_r;

    assign step_s       = en & ~clear & (cnt_r == CNT_LAST);
    assign read_address = addr_r;
    assign quadrant     = quad_r;

    // Prescaler: counts enabled cycles, wraps on the step cycle, holds while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= CNT_ZERO;
        end else if (clear) begin
            cnt_r <= CNT_ZERO;
        end else if (en) begin
            cnt_r <= (cnt_r == CNT_LAST) ? CNT_ZERO : cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Quadrant/address state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quad_r <= Q0;
            addr_r <= ADDR_ZERO;
        end else if (clear) begin
            quad_r <= Q0;
            addr_r <= ADDR_ZERO;
        end else begin
            quad_r <= quad_nxt_s;
            addr_r <= addr_nxt_s;
        end
    end

    // Next-state: endpoints are held for one extra step so each quadrant emits all addresses
    always_comb begin
        quad_nxt_s = quad_r;
        addr_nxt_s = addr_r;
        if (step_s) begin
            case (quad_r)
                Q0: begin
                    if (addr_r == ADDR_MAX) quad_nxt_s = Q1;
                    else                    addr_nxt_s = addr_r + ADDR_ONE;
                end
                Q1: begin
                    if (addr_r == ADDR_ZERO) quad_nxt_s = Q2;
                    else                     addr_nxt_s = addr_r - ADDR_ONE;
                end
                Q2: begin
                    if (addr_r == ADDR_MAX) quad_nxt_s = Q3;
                    else                    addr_nxt_s = addr_r + ADDR_ONE;
                end
                Q3: begin
                    if (addr_r == ADDR_ZERO) quad_nxt_s = Q0;
                    else                     addr_nxt_s = addr_r - ADDR_ONE;
                end
                default: begin
                    quad_nxt_s = Q0;
                    addr_nxt_s = ADDR_ZERO;
                end
            endcase
        end else begin
            quad_nxt_s = quad_r;
            addr_nxt_s = addr_r;
        end
    end

    // FSM outputs: tags that travel alongside the memory read
    always_comb begin
        tag_neg_s   = quad_r[1];
        tag_first_s = 1'b0;
        if ((quad_r == Q0) && (addr_r == ADDR_ZERO)) begin
            tag_first_s = 1'b1;
        end else begin
            tag_first_s = 1'b0;
        end
    end

    // Tag stage 1: aligned with the memory's registered read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid1_r <= 1'b0;
            neg1_r   <= 1'b0;
            first1_r <= 1'b0;
        end else if (clear) begin
            valid1_r <= 1'b0;
            neg1_r   <= neg1_r;
            first1_r <= first1_r;
        end else if (step_s) begin
            valid1_r <= 1'b1;
            neg1_r   <= tag_neg_s;
            first1_r <= tag_first_s;
        end else begin
            valid1_r <= 1'b0;
            neg1_r   <= neg1_r;
            first1_r <= first1_r;
        end
    end

    // Output register: negative half is the ones' complement, i.e. 511-d; clear drops in-flight data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_out   <= MIDSCALE;
            sample_valid <= 1'b0;
            period_start <= 1'b0;
        end else if (clear) begin
            sample_out   <= sample_out;
            sample_valid <= 1'b0;
            period_start <= 1'b0;
        end else begin
            sample_valid <= valid1_r;
            period_start <= valid1_r & first1_r;
            if (valid1_r) begin
                sample_out <= neg1_r ? {1'b0, ~read_data} : {1'b1, read_data};
            end else begin
                sample_out <= sample_out;
            end
        end
    end

endmodule

// File: tb/tb_sine_quadrant_sequencer.sv
// Bench for sine_quadrant_sequencer: two instances (STEP_DIV=1 and 4) fed by
// registered memory models holding data[i]=4*i, checked against a phase-based model.
module tb_sine_quadrant_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;

    logic [6:0] ra1, ra4;
    logic [8:0] rd1, rd4;
    logic [9:0] so1, so4;
    logic       sv1, sv4, ps1, ps4;
    logic [1:0] q1, q4;

    int vectors = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sine_quadrant_sequencer #(.ADDR_WIDTH(7), .DATA_WIDTH(9), .STEP_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .read_address(ra1), .read_data(rd1), .sample_out(so1),
        .sample_valid(sv1), .quadrant(q1), .period_start(ps1));

    sine_quadrant_sequencer #(.ADDR_WIDTH(7), .DATA_WIDTH(9), .STEP_DIV(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .clear(clear),
        .read_address(ra4), .read_data(rd4), .sample_out(so4),
        .sample_valid(sv4), .quadrant(q4), .period_start(ps4));

    // Sample memories with 1-clock registered read
    always @(posedge clk) begin
        rd1 <= {ra1, 2'b00};
        rd4 <= {ra4, 2'b00};
    end

    // Reference model: a phase counter 0..511 per instance plus a two-deep output pipeline
    int ph[2], cnt[2], v1val[2], osmp[2];
    bit v1v[2], v1f[2], ov[2], ops[2];
    bit m_step;

    function automatic int div_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic int addr_of(int p);
        int q, i;
        q = p / 128;
        i = p % 128;
        return (q % 2 == 0) ? i : 127 - i;
    endfunction

    function automatic int val_of(int p);
        return (p / 128 >= 2) ? 511 - 4 * addr_of(p) : 512 + 4 * addr_of(p);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                ph[k] = 0; cnt[k] = 0; v1v[k] = 0; v1val[k] = 0; v1f[k] = 0;
                ov[k] = 0; ops[k] = 0; osmp[k] = 512;
            end else if (clear) begin
                ph[k] = 0; cnt[k] = 0; v1v[k] = 0; ov[k] = 0; ops[k] = 0;
            end else begin
                m_step = en && (cnt[k] == div_of(k) - 1);
                ov[k]  = v1v[k];
                ops[k] = v1v[k] && v1f[k];
                if (v1v[k]) osmp[k] = v1val[k];
                v1v[k] = m_step;
                if (m_step) begin
                    v1val[k] = val_of(ph[k]);
                    v1f[k]   = (ph[k] == 0);
                    ph[k]    = (ph[k] + 1) % 512;
                end
                if (en) cnt[k] = (cnt[k] == div_of(k) - 1) ? 0 : cnt[k] + 1;
            end
        end
    end

    // Spec-level expected stream for the n-th valid sample after a restart
    function automatic int stream_of(int n);
        int s, j;
        s = (n % 512) / 128;
        j = n % 128;
        case (s)
            0: return 512 + 4 * j;
            1: return 1020 - 4 * j;
            2: return 511 - 4 * j;
            default: return 3 + 4 * j;
        endcase
    endfunction

    task automatic restart();
        @(negedge clk); clear = 1'b1;
        @(negedge clk); clear = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if (ra1 !== 7'd0 || q1 !== 2'd0 || so1 !== 10'd512 || sv1 !== 1'b0 || ps1 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: addr=%0d quad=%0d out=%0d valid=%0b ps=%0b, required 0/0/512/0/0",
                     ra1, q1, so1, sv1, ps1);
        end
        vectors++;
        if (ra4 !== 7'd0 || so4 !== 10'd512 || sv4 !== 1'b0) begin
            fails++;
            $display("FAIL reset_state_div4: addr=%0d out=%0d valid=%0b, required 0/512/0", ra4, so4, sv4);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_full_period();
        int n = 0;
        int cyc = 0;
        @(negedge clk); en = 1'b1;
        while (n < 520 && cyc < 700) begin
            @(negedge clk); cyc++;
            if (sv1) begin
                vectors++;
                if (so1 !== 10'(stream_of(n)) || ps1 !== (n % 512 == 0)) begin
                    fails++;
                    $display("FAIL full_period[%0d]: out=%0d ps=%0b, required %0d ps=%0b",
                             n, so1, ps1, stream_of(n), (n % 512 == 0));
                end
                n++;
            end
        end
        vectors++;
        if (n < 520) begin
            fails++;
            $display("FAIL full_period_count: got %0d valids, required 520", n);
        end
    endtask

    task automatic test_async_reset();
        int cyc = 0;
        while (q1 !== 2'd2 && cyc < 700) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (ra1 !== 7'd0 || q1 !== 2'd0 || so1 !== 10'd512 || sv1 !== 1'b0 || cyc >= 700) begin
            fails++;
            $display("FAIL async_reset_mid_q2: addr=%0d quad=%0d out=%0d valid=%0b wait=%0d, required 0/0/512/0",
                     ra1, q1, so1, sv1, cyc);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_boundary();
        int cyc = 0;
        logic [6:0] ea[4];
        logic [1:0] eq[4];
        ea[0] = 7'd126; ea[1] = 7'd127; ea[2] = 7'd127; ea[3] = 7'd126;
        eq[0] = 2'd0;   eq[1] = 2'd0;   eq[2] = 2'd1;   eq[3] = 2'd1;
        restart();
        while (!(ra1 == 7'd126 && q1 == 2'd0) && cyc < 300) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (ra1 !== ea[i] || q1 !== eq[i] || cyc >= 300) begin
                fails++;
                $display("FAIL q0_q1_boundary[%0d]: addr=%0d quad=%0d, required %0d/%0d",
                         i, ra1, q1, ea[i], eq[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_prescale();
        int last_v = -1, last_c = -1, nv = 0, nc = 0;
        logic [6:0] prev;
        restart();
        prev = ra4;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (sv4) begin
                if (last_v >= 0) begin
                    vectors++;
                    if (c - last_v != 4) begin
                        fails++;
                        $display("FAIL div4_valid_gap: gap=%0d, required 4", c - last_v);
                    end
                end
                last_v = c; nv++;
            end
            if (ra4 != prev) begin
                if (last_c >= 0) begin
                    vectors++;
                    if (c - last_c != 4) begin
                        fails++;
                        $display("FAIL div4_addr_gap: gap=%0d, required 4", c - last_c);
                    end
                end
                last_c = c; nc++; prev = ra4;
            end
        end
        vectors++;
        if (nv < 18 || nc < 18) begin
            fails++;
            $display("FAIL div4_counts: valids=%0d addr_changes=%0d, required >=18 each", nv, nc);
        end
    endtask

    task automatic test_en_hold();
        int cyc = 0, pulses = 0;
        restart();
        while (!(ra1 == 7'd60 && q1 == 2'd1) && cyc < 400) begin @(negedge clk); cyc++; end
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sv1) pulses++;
            vectors++;
            if (ra1 !== 7'd60 || q1 !== 2'd1 || cyc >= 400) begin
                fails++;
                $display("FAIL en_hold_addr[%0d]: addr=%0d quad=%0d, required 60/1", i, ra1, q1);
            end
        end
        vectors++;
        if (pulses > 1) begin
            fails++;
            $display("FAIL en_hold_pulses: got %0d, required <=1", pulses);
        end
        en = 1'b1;
        @(negedge clk);
        vectors++;
        if (ra1 !== 7'd59 || q1 !== 2'd1) begin
            fails++;
            $display("FAIL en_resume_addr: addr=%0d quad=%0d, required 59/1", ra1, q1);
        end
        cyc = 0;
        while (!sv1 && cyc < 4) begin @(negedge clk); cyc++; end
        vectors++;
        if (sv1 !== 1'b1 || so1 !== 10'd752) begin
            fails++;
            $display("FAIL en_resume_sample: valid=%0b out=%0d, required 1/752", sv1, so1);
        end
    endtask

    task automatic test_clear();
        int cyc = 0;
        logic [9:0] held;
        restart();
        while (!(ra1 == 7'd100 && q1 == 2'd2) && cyc < 500) begin @(negedge clk); cyc++; end
        held = so1;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        vectors++;
        if (ra1 !== 7'd0 || q1 !== 2'd0 || sv1 !== 1'b0 || so1 !== held || cyc >= 500) begin
            fails++;
            $display("FAIL clear_q2: addr=%0d quad=%0d valid=%0b out=%0d, required 0/0/0/%0d",
                     ra1, q1, sv1, so1, held);
        end
        cyc = 0;
        @(negedge clk);
        while (!sv1 && cyc < 5) begin @(negedge clk); cyc++; end
        vectors++;
        if (sv1 !== 1'b1 || so1 !== 10'd512 || ps1 !== 1'b1) begin
            fails++;
            $display("FAIL clear_restart: valid=%0b out=%0d ps=%0b, required 1/512/1", sv1, so1, ps1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            vectors++;
            if (ra1 !== 7'(addr_of(ph[0])) || q1 !== 2'(ph[0] / 128) || sv1 !== ov[0] ||
                ps1 !== ops[0] || so1 !== 10'(osmp[0])) begin
                fails++;
                $display("FAIL random_div1@%0d: addr=%0d quad=%0d v=%0b ps=%0b out=%0d, required %0d/%0d/%0b/%0b/%0d",
                         c, ra1, q1, sv1, ps1, so1, addr_of(ph[0]), ph[0] / 128, ov[0], ops[0], osmp[0]);
            end
            vectors++;
            if (ra4 !== 7'(addr_of(ph[1])) || q4 !== 2'(ph[1] / 128) || sv4 !== ov[1] ||
                ps4 !== ops[1] || so4 !== 10'(osmp[1])) begin
                fails++;
                $display("FAIL random_div4@%0d: addr=%0d quad=%0d v=%0b ps=%0b out=%0d, required %0d/%0d/%0b/%0b/%0d",
                         c, ra4, q4, sv4, ps4, so4, addr_of(ph[1]), ph[1] / 128, ov[1], ops[1], osmp[1]);
            end
            en    = ($urandom_range(3, 0) != 0);
            clear = ($urandom_range(99, 0) < 2);
        end
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_period();
        test_async_reset();
        test_boundary();
        test_prescale();
        test_en_hold();
        test_clear();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
